mpu_add_sequencer: RTL
======================

Name: mpu_add_sequencer

Overview:
Sequences the element-wise 5x5 8-bit matrix adder for the MPU. On a start command it streams matrix A, then matrix B, one byte per cycle from a single-port byte memory into internal 200-bit operand registers. It presents those registers to the combinational add datapath, latches the sum, and streams the 25 result bytes back to memory. It sits between the MPU command/issue logic and the shared byte memory, and owns the only instance of the add datapath.

Parameters:
ADDR_W, 8, width of memory byte address and of base-address inputs
N_ELEM, 25, elements per matrix (5x5); fixed, not intended to be overridden

Ports:
clock  input  1  single clock, all state on rising edge
reset  input  1  synchronous, active-high
start  input  1  command pulse; sampled only in IDLE
base_a  input  ADDR_W  byte address of A[0]
base_b  input  ADDR_W  byte address of B[0]
base_r  input  ADDR_W  byte address of R[0]
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the result is fully written
mem_addr  output  ADDR_W  memory byte address
mem_rd_en  output  1  read strobe; data returns on mem_rdata exactly 1 cycle later
mem_rdata  input  8  read data
mem_wr_en  output  1  write strobe; write commits on the same edge
mem_wdata  output  8  write data
dp_matrix_a  output  200  operand A to add datapath (element k at bits [8k+:8])
dp_matrix_b  output  200  operand B to add datapath
dp_result  input  200  combinational sum from datapath, per-byte mod 256

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Element index k = i + 5*j, stored at byte lane [8k+:8]. Memory address = base + k, computed mod 2^ADDR_W; wrap past all-ones is legal and silent.
- Reset: state IDLE; busy=0, done=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0; dp_matrix_a, dp_matrix_b and the result register cleared to 0. Reset mid-operation aborts the same cycle: no further strobes, and no done.
- States: IDLE, LOAD_A, LOAD_B, EXEC, LATCH, STORE, DONE.
- IDLE: on start=1, latch base_a/b/r, clear the element counter, go to LOAD_A. start is ignored in all other states. Bases are not re-sampled while busy.
- LOAD_A: 25 cycles; cycle k drives mem_rd_en=1 and mem_addr=base_a+k. After counter=24, go to LOAD_B with counter=0.
- LOAD_B: same pattern at base_b+k, then go to EXEC.
- Capture pipeline: a 1-cycle delayed {valid, select, index} tag writes mem_rdata into byte k of A or B. A[24] is therefore captured in the first LOAD_B cycle, and B[24] in the EXEC cycle.
- EXEC: 1 cycle, no strobes; B[24] lands. Then go to LATCH.
- LATCH: 1 cycle; the result register takes dp_result. Then go to STORE with counter=0.
- STORE: 25 cycles; cycle k drives mem_wr_en=1, mem_addr=base_r+k, mem_wdata=result[8k+:8]. Then go to DONE.
- DONE: done=1 for exactly one cycle, busy still 1, then go to IDLE.
- Latency: with start sampled at edge 0, LOAD_A covers cycles 1-25, LOAD_B 26-50, EXEC 51, LATCH 52, STORE 53-77, DONE 78. A new start is accepted in cycle 79 at the earliest.
- mem_rd_en and mem_wr_en are never high together. Both are 0 outside LOAD_*/STORE.
- Overlapping regions (base_r inside A or B) are legal: all reads complete before the first write.
- Arithmetic overflow is wrap mod 256, owned by the datapath; the sequencer raises no flag.
- dp_matrix_a and dp_matrix_b hold their values after completion until the next LOAD overwrites them.

Test Plan:
- A=1..25 at base_a=0x00, B=25..1 at base_b=0x20, base_r=0x40, start pulse -> memory 0x40..0x58 all = 26; done high exactly in cycle 78; busy high in cycles 1-78.
- A all 0xFF, B all 0x02 -> every result byte = 0x01 (wrap); no extra strobes beyond the 25 writes.
- base_a=0xF0, ADDR_W=8 -> reads at 0xF0..0xFF then 0x00..0x08, with mem_rdata matched to element index.
- start held high through an entire op -> exactly one op, one done pulse; a second op starts in cycle 79.
- reset asserted in cycle 30 (mid LOAD_B) -> next cycle IDLE, busy=0, strobes 0, no writes, done never pulses; a fresh start then completes correctly.
- base_r=base_a (in-place) with A=1..25, B=1..25 -> region holds 2,4,...,50; a strobe monitor sees reads and writes never overlap.

Source files
------------

// File: rtl/mpu_add_sequencer.sv
// mpu_add_sequencer: drives the 5x5 byte-matrix add.
// Streams A then B from byte memory into operand registers, latches the
// datapath sum, then writes the 25 result bytes back to memory.
module mpu_add_sequencer #(
    parameter int ADDR_W = 8,
    parameter int N_ELEM = 25
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_a,
    input  logic [ADDR_W-1:0]   base_b,
    input  logic [ADDR_W-1:0]   base_r,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_rd_en,
    input  logic [7:0]          mem_rdata,
    output logic                mem_wr_en,
    output logic [7:0]          mem_wdata,
    output logic [8*N_ELEM-1:0] dp_matrix_a,
    output logic [8*N_ELEM-1:0] dp_matrix_b,
    input  logic [8*N_ELEM-1:0] dp_result
);

    localparam int              CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_ELEM - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_LATCH, S_STORE, S_DONE
    } state_t;

    state_t              r_state, w_state_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic [ADDR_W-1:0]   r_base_a, r_base_b, r_base_r;
    logic                r_cap_valid, r_cap_sel;
    logic [CNT_W-1:0]    r_cap_idx;
    logic [8*N_ELEM-1:0] r_mat_a, r_mat_b, r_result;
    logic                w_rd, w_wr, w_done;
    logic [ADDR_W-1:0]   w_addr, w_cnt_ext;
    logic [7:0]          w_wdata;

    assign w_cnt_ext = ADDR_W'(r_cnt);

    // Next-state, element counter and strobe decode for the current state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_rd         = 1'b0;
        w_wr         = 1'b0;
        w_done       = 1'b0;
        w_addr       = '0;
        w_wdata      = '0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_LOAD_A;
                    w_cnt_next   = '0;
                end
            end
            S_LOAD_A: begin
                w_rd   = 1'b1;
                w_addr = r_base_a + w_cnt_ext;
                if (r_cnt == LAST) begin
                    w_state_next = S_LOAD_B;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_LOAD_B: begin
                w_rd   = 1'b1;
                w_addr = r_base_b + w_cnt_ext;
                if (r_cnt == LAST) begin
                    w_state_next = S_EXEC;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_EXEC: begin
                w_state_next = S_LATCH;
            end
            S_LATCH: begin
                w_state_next = S_STORE;
                w_cnt_next   = '0;
            end
            S_STORE: begin
                w_wr    = 1'b1;
                w_addr  = r_base_r + w_cnt_ext;
                w_wdata = r_result[{r_cnt, 3'b000} +: 8];
                if (r_cnt == LAST) begin
                    w_state_next = S_DONE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Strobes and done drop in the reset cycle itself so an abort issues nothing further.
    assign busy        = (r_state != S_IDLE);
    assign done        = w_done & ~reset;
    assign mem_rd_en   = w_rd & ~reset;
    assign mem_wr_en   = w_wr & ~reset;
    assign mem_addr    = w_addr;
    assign mem_wdata   = w_wdata;
    assign dp_matrix_a = r_mat_a;
    assign dp_matrix_b = r_mat_b;

    // State register, element counter and base addresses captured on start.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_base_a <= '0;
            r_base_b <= '0;
            r_base_r <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (r_state == S_IDLE && start) begin
                r_base_a <= base_a;
                r_base_b <= base_b;
                r_base_r <= base_r;
            end
        end
    end

    // Read-return pipeline: tag each read, then drop the returned byte into its lane.
    always_ff @(posedge clock) begin
        // NOTE: the operand registers are observable outputs that must read zero after reset, so they are reset like control state.
        if (reset) begin
            r_cap_valid <= 1'b0;
            r_cap_sel   <= 1'b0;
            r_cap_idx   <= '0;
            r_mat_a     <= '0;
            r_mat_b     <= '0;
        end else begin
            r_cap_valid <= w_rd;
            r_cap_sel   <= (r_state == S_LOAD_B);
            r_cap_idx   <= r_cnt;
            if (r_cap_valid) begin
                if (r_cap_sel) begin
                    r_mat_b[{r_cap_idx, 3'b000} +: 8] <= mem_rdata;
                end else begin
                    r_mat_a[{r_cap_idx, 3'b000} +: 8] <= mem_rdata;
                end
            end
        end
    end

    // Result register samples the datapath sum once both operands are complete.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_result <= '0;
        end else if (r_state == S_LATCH) begin
            r_result <= dp_result;
        end
    end

endmodule
